// File: rtl/alu_op_sequencer_pkg.sv
// alu_op_sequencer_pkg: shared ALU opcodes, default width and sequencer FSM states
package alu_op_sequencer_pkg;
  localparam int ALU_DW = 16;
  localparam logic [2:0] ALU_OP_PASS = 3'b000;
  localparam logic [2:0] ALU_OP_ADD  = 3'b001;
  localparam logic [2:0] ALU_OP_SUB  = 3'b010;
  localparam logic [2:0] ALU_OP_MUL  = 3'b011;
  localparam logic [2:0] ALU_OP_DIV  = 3'b100;
  localparam logic [2:0] ALU_OP_XOR  = 3'b101;
  localparam logic [2:0] ALU_OP_MOD  = 3'b110;
  localparam logic [2:0] ALU_OP_AND  = 3'b111;
  typedef enum logic [1:0] {S_IDLE, S_READ, S_EXEC, S_WB} state_t;
endpackage

// File: rtl/alu_op_sequencer_regfile.sv
// alu_op_sequencer_regfile: 2**AW x DW register file, two async read ports, write-back beats direct load
module alu_op_sequencer_regfile #(
  parameter int DW = 16,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] raddr1,
  input  logic [AW-1:0] raddr2,
  output logic [DW-1:0] rdata1,
  output logic [DW-1:0] rdata2,
  input  logic          wb_we,
  input  logic [AW-1:0] wb_addr,
  input  logic [DW-1:0] wb_data,
  input  logic          ld_we,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_data
);
  logic [DW-1:0] regs [2**AW];
  assign rdata1 = regs[raddr1];
  assign rdata2 = regs[raddr2];
  // later assignment wins on an address collision, giving write-back priority
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) regs <= '{default: '0};
    else begin
      if (ld_we) regs[ld_addr] <= ld_data;
      if (wb_we) regs[wb_addr] <= wb_data;
    end
endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: register-addressed command issue to an external combinational ALU.
// Define ALU_SEQ_DIVZERO_CHECK_EN to trap DIV/MOD by zero (rsp_err=1, no write-back).
module alu_op_sequencer
  import alu_op_sequencer_pkg::*;
#(
  parameter int DW = ALU_DW,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [2:0]    cmd_op,
  input  logic [AW-1:0] cmd_rd,
  input  logic [AW-1:0] cmd_rs1,
  input  logic [AW-1:0] cmd_rs2,
  input  logic          ld_en,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_data,
  output logic [DW-1:0] alu_din1,
  output logic [DW-1:0] alu_din2,
  output logic [2:0]    alu_ms,
  input  logic [DW-1:0] alu_out,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_data,
  output logic [AW-1:0] rsp_rd,
  output logic          rsp_err
);
  state_t state, state_nxt;
  logic [2:0] op_q;
  logic [AW-1:0] rs1_q, rs2_q;
  logic [DW-1:0] rdata1, rdata2;
  logic accept, wr_pend, err_q, err_nxt;
  always_comb begin
    cmd_ready = state == S_IDLE;
    rsp_valid = state == S_WB;
    accept = cmd_ready && cmd_valid;
    state_nxt = state == S_IDLE ? (cmd_valid ? S_READ : S_IDLE) :
                state == S_READ ? S_EXEC :
                state == S_EXEC ? S_WB :
                rsp_ready ? S_IDLE : S_WB;
  end
`ifdef ALU_SEQ_DIVZERO_CHECK_EN
  assign err_nxt = (op_q == ALU_OP_DIV || op_q == ALU_OP_MOD) && rdata2 == '0;
`else
  assign err_nxt = 1'b0;
`endif
  assign rsp_err = rsp_valid && err_q;
  // wr_pend marks only the first WB cycle, so a stalled response never rewrites
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= S_IDLE;
      op_q <= '0;
      rs1_q <= '0;
      rs2_q <= '0;
      rsp_rd <= '0;
      rsp_data <= '0;
      alu_din1 <= '0;
      alu_din2 <= '0;
      alu_ms <= ALU_OP_PASS;
      wr_pend <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state <= state_nxt;
      wr_pend <= state == S_EXEC;
      if (accept) begin
        op_q <= cmd_op;
        rsp_rd <= cmd_rd;
        rs1_q <= cmd_rs1;
        rs2_q <= cmd_rs2;
      end
      if (state == S_READ) begin
        alu_din1 <= rdata1;
        alu_din2 <= rdata2;
        err_q <= err_nxt;
        alu_ms <= err_nxt ? ALU_OP_PASS : op_q;
      end
      if (state == S_EXEC) rsp_data <= err_q ? '0 : alu_out;
      if (rsp_valid && rsp_ready) alu_ms <= ALU_OP_PASS;
    end
  alu_op_sequencer_regfile #(.DW(DW), .AW(AW)) u_regfile (
    .clk(clk),
    .rst_n(rst_n),
    .raddr1(rs1_q),
    .raddr2(rs2_q),
    .rdata1(rdata1),
    .rdata2(rdata2),
    .wb_we(wr_pend && !err_q),
    .wb_addr(rsp_rd),
    .wb_data(rsp_data),
    .ld_we(ld_en),
    .ld_addr(ld_addr),
    .ld_data(ld_data)
  );
endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: randomized and directed checks of alu_op_sequencer against a register-array model
module tb_alu_op_sequencer;
  logic clk, rst_n, cmd_valid, cmd_ready, ld_en, rsp_valid, rsp_ready, rsp_err;
  logic [2:0] cmd_op, cmd_rd, cmd_rs1, cmd_rs2, ld_addr, alu_ms, rsp_rd;
  logic [15:0] ld_data, alu_din1, alu_din2, alu_out, rsp_data;
  logic [15:0] mdl [8];
  int total = 0, bad = 0;
  time t_rsp;

  alu_op_sequencer dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_rd(cmd_rd), .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .alu_din1(alu_din1), .alu_din2(alu_din2), .alu_ms(alu_ms), .alu_out(alu_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_rd(rsp_rd), .rsp_err(rsp_err)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  function automatic logic [15:0] alu_f(input logic [2:0] ms, input logic [15:0] a, input logic [15:0] b);
    case (ms)
      3'd0: return a;
      3'd1: return a + b;
      3'd2: return a - b;
      3'd3: return a * b;
      3'd4: return b == 0 ? 16'hFFFF : a / b;
      3'd5: return a ^ b;
      3'd6: return b == 0 ? a : a % b;
      default: return a & b;
    endcase
  endfunction

  // stand-in for the external combinational ALU
  always_comb alu_out = alu_f(alu_ms, alu_din1, alu_din2);

  task automatic do_ld(input logic [2:0] addr, input logic [15:0] data);
    ld_en = 1; ld_addr = addr; ld_data = data;
    @(posedge clk); #1;
    ld_en = 0;
    mdl[addr] = data;
  endtask

  // coll: 0 none, 1 ld 0xAAAA to rd in first WB cycle, 2 ld v to rd in a stalled WB cycle, 3 ld v to rs1 during READ
  task automatic do_cmd(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs1, input logic [2:0] rs2,
                        input int hold, input int coll, input logic [15:0] v);
    logic [15:0] a, b, exp_d;
    logic exp_err;
    int n;
    a = mdl[rs1];
    b = mdl[rs2];
`ifdef ALU_SEQ_DIVZERO_CHECK_EN
    exp_err = (op == 3'd4 || op == 3'd6) && b == 0;
`else
    exp_err = 1'b0;
`endif
    exp_d = exp_err ? 16'h0000 : alu_f(op, a, b);
    n = 0;
    while (!cmd_ready && n < 10) begin @(posedge clk); #1; n++; end
    total++;
    if (cmd_ready !== 1'b1) begin bad++; $display("FAIL cmd_ready_wait got=%b want=1", cmd_ready); end
    cmd_valid = 1; cmd_op = op; cmd_rd = rd; cmd_rs1 = rs1; cmd_rs2 = rs2;
    rsp_ready = (hold == 0);
    @(posedge clk); #1;
    cmd_valid = 0;
    if (coll == 3) begin ld_en = 1; ld_addr = rs1; ld_data = v; end
    total++;
    if (cmd_ready !== 1'b0) begin bad++; $display("FAIL cmd_ready_busy got=%b want=0", cmd_ready); end
    @(posedge clk); #1;
    ld_en = 0;
    total++;
    if ({alu_ms, alu_din1, alu_din2} !== {(exp_err ? 3'd0 : op), a, b}) begin
      bad++; $display("FAIL exec_drive got ms=%0d d1=%h d2=%h want ms=%0d d1=%h d2=%h",
                      alu_ms, alu_din1, alu_din2, exp_err ? 3'd0 : op, a, b);
    end
    n = 2;
    while (!rsp_valid && n < 10) begin @(posedge clk); #1; n++; end
    t_rsp = $time;
    total++;
    if (n !== 3) begin bad++; $display("FAIL latency got=%0d want=3", n); end
    total++;
    if ({rsp_valid, rsp_data, rsp_rd, rsp_err} !== {1'b1, exp_d, rd, exp_err}) begin
      bad++; $display("FAIL rsp op=%0d got v=%b d=%h rd=%0d e=%b want v=1 d=%h rd=%0d e=%b",
                      op, rsp_valid, rsp_data, rsp_rd, rsp_err, exp_d, rd, exp_err);
    end
    if (coll == 1) begin ld_en = 1; ld_addr = rd; ld_data = 16'hAAAA; end
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      ld_en = 0;
      total++;
      if ({rsp_valid, cmd_ready, rsp_data, rsp_rd} !== {1'b1, 1'b0, exp_d, rd}) begin
        bad++; $display("FAIL stall_hold k=%0d got v=%b cr=%b d=%h rd=%0d want v=1 cr=0 d=%h rd=%0d",
                        k, rsp_valid, cmd_ready, rsp_data, rsp_rd, exp_d, rd);
      end
      if (coll == 2 && k == 1) begin ld_en = 1; ld_addr = rd; ld_data = v; end
    end
    rsp_ready = 1;
    @(posedge clk); #1;
    ld_en = 0;
    total++;
    if ({rsp_valid, alu_ms, cmd_ready} !== {1'b0, 3'd0, 1'b1}) begin
      bad++; $display("FAIL rsp_done got v=%b ms=%0d cr=%b want v=0 ms=0 cr=1", rsp_valid, alu_ms, cmd_ready);
    end
    if (coll == 3) mdl[rs1] = v;
    if (!exp_err) mdl[rd] = exp_d;
    else if (coll == 1) mdl[rd] = 16'hAAAA;
    if (coll == 2) mdl[rd] = v;
  endtask

  task automatic check_regs;
    for (int r = 0; r < 8; r++) do_cmd(3'd0, 3'(r), 3'(r), 3'(r), 0, 0, 16'h0);
  endtask

  task automatic test_reset;
    #2 rst_n = 0;
    #1;
    total++;
    if ({rsp_valid, rsp_data, rsp_rd, rsp_err, alu_ms, alu_din1, alu_din2} !== '0) begin
      bad++; $display("FAIL reset_outputs got v=%b d=%h rd=%0d e=%b ms=%0d d1=%h d2=%h want all 0",
                      rsp_valid, rsp_data, rsp_rd, rsp_err, alu_ms, alu_din1, alu_din2);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    total++;
    if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", cmd_ready); end
    for (int r = 0; r < 8; r++) mdl[r] = 16'h0;
  endtask

  task automatic test_directed;
    do_ld(3'd1, 16'h0005); do_ld(3'd2, 16'h0003);
    do_cmd(3'd1, 3'd3, 3'd1, 3'd2, 0, 0, 16'h0);
    do_cmd(3'd0, 3'd3, 3'd3, 3'd3, 0, 0, 16'h0);
    do_ld(3'd1, 16'h0003); do_ld(3'd2, 16'h0005);
    do_cmd(3'd2, 3'd4, 3'd1, 3'd2, 0, 0, 16'h0);
    do_ld(3'd1, 16'h0100); do_ld(3'd2, 16'h0100);
    do_cmd(3'd3, 3'd5, 3'd1, 3'd2, 0, 0, 16'h0);
    do_ld(3'd1, 16'h0007); do_ld(3'd2, 16'h0000); do_ld(3'd6, 16'h1234);
    do_cmd(3'd4, 3'd6, 3'd1, 3'd2, 0, 0, 16'h0);
    do_cmd(3'd6, 3'd7, 3'd1, 3'd2, 0, 0, 16'h0);
    do_cmd(3'd1, 3'd1, 3'd1, 3'd1, 0, 0, 16'h0);
    check_regs();
  endtask

  task automatic test_backpressure;
    do_ld(3'd2, 16'h0011); do_ld(3'd5, 16'h0022);
    do_cmd(3'd5, 3'd4, 3'd2, 3'd5, 10, 0, 16'h0);
    do_cmd(3'd1, 3'd4, 3'd2, 3'd5, 10, 2, 16'h5A5A);
    do_cmd(3'd0, 3'd4, 3'd4, 3'd4, 0, 0, 16'h0);
  endtask

  task automatic test_collisions;
    do_ld(3'd0, 16'h0040); do_ld(3'd3, 16'h0002);
    do_cmd(3'd7, 3'd3, 3'd0, 3'd3, 0, 1, 16'h0);
    do_cmd(3'd1, 3'd5, 3'd0, 3'd3, 3, 1, 16'h0);
    do_cmd(3'd2, 3'd6, 3'd0, 3'd0, 0, 3, 16'h7777);
    do_ld(3'd2, 16'h0000);
    do_cmd(3'd4, 3'd2, 3'd0, 3'd2, 0, 1, 16'h0);
    check_regs();
  endtask

  task automatic test_back_to_back;
    time prev;
    for (int i = 0; i < 6; i++) begin
      prev = t_rsp;
      do_cmd(3'($urandom_range(0, 7)), 3'($urandom), 3'($urandom), 3'($urandom), 0, 0, 16'h0);
      if (i > 0) begin
        total++;
        if (t_rsp - prev !== 40) begin bad++; $display("FAIL throughput got=%0t want=40", t_rsp - prev); end
      end
    end
  endtask

  task automatic test_random;
    int coll, hold;
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 1) == 1) do_ld(3'($urandom), 16'($urandom));
      if ($urandom_range(0, 7) == 0) do_ld(3'($urandom), 16'h0000);
      coll = $urandom_range(0, 3);
      hold = coll == 2 ? $urandom_range(2, 5) : $urandom_range(0, 2);
      do_cmd(3'($urandom), 3'($urandom), 3'($urandom), 3'($urandom), hold, coll, 16'($urandom));
    end
    check_regs();
  endtask

  task automatic test_reset_mid;
    do_ld(3'd1, 16'h00F0); do_ld(3'd2, 16'h000F);
    cmd_valid = 1; cmd_op = 3'd1; cmd_rd = 3'd3; cmd_rs1 = 3'd1; cmd_rs2 = 3'd2;
    @(posedge clk); #1;
    cmd_valid = 0;
    @(posedge clk); #2;
    rst_n = 0;
    #1;
    total++;
    if ({rsp_valid, alu_ms, alu_din1, alu_din2, rsp_rd} !== '0) begin
      bad++; $display("FAIL reset_mid got v=%b ms=%0d d1=%h d2=%h rd=%0d want all 0",
                      rsp_valid, alu_ms, alu_din1, alu_din2, rsp_rd);
    end
    @(posedge clk); #1;
    rst_n = 1;
    total++;
    if ({cmd_ready, rsp_valid} !== 2'b10) begin
      bad++; $display("FAIL reset_mid_idle got cr=%b v=%b want cr=1 v=0", cmd_ready, rsp_valid);
    end
    for (int r = 0; r < 8; r++) mdl[r] = 16'h0;
    check_regs();
  endtask

  initial begin
    rst_n = 1; cmd_valid = 0; cmd_op = 0; cmd_rd = 0; cmd_rs1 = 0; cmd_rs2 = 0;
    ld_en = 0; ld_addr = 0; ld_data = 0; rsp_ready = 1; t_rsp = 0;
    test_reset();
    test_directed();
    test_backpressure();
    test_collisions();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
